// File: rtl/np_pkg.sv
// Shared constants, mode encodings and colour helpers for the pixel pattern path.
package np_pkg;

  localparam int HUE_MAX = 768;
  localparam int HUE_W   = 10;
  localparam int COLOR_W = 8;

  typedef enum logic [1:0] {
    MODE_RAINBOW = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  function automatic logic [3*COLOR_W-1:0] pack_grb(input logic [COLOR_W-1:0] r,
                                                     input logic [COLOR_W-1:0] g,
                                                     input logic [COLOR_W-1:0] b);
    return {g, r, b};
  endfunction

  function automatic logic [COLOR_W-1:0] grb_g(input logic [3*COLOR_W-1:0] c);
    return c[3*COLOR_W-1:2*COLOR_W];
  endfunction

  function automatic logic [COLOR_W-1:0] grb_r(input logic [3*COLOR_W-1:0] c);
    return c[2*COLOR_W-1:COLOR_W];
  endfunction

  function automatic logic [COLOR_W-1:0] grb_b(input logic [3*COLOR_W-1:0] c);
    return c[COLOR_W-1:0];
  endfunction

  // Both operands stay below HUE_MAX, so one conditional subtract is a full modulo.
  function automatic logic [HUE_W-1:0] hue_add(input logic [HUE_W-1:0] h, input int step);
    logic [HUE_W:0] s;
    s = {1'b0, h} + (HUE_W+1)'(step);
    return (s >= (HUE_W+1)'(HUE_MAX)) ? HUE_W'(s - (HUE_W+1)'(HUE_MAX)) : s[HUE_W-1:0];
  endfunction

endpackage

// File: rtl/rainbow_pattern_gen_if.sv
// Valid/ready pixel stream from the pattern generator to the neopixel serialiser.
interface rainbow_pattern_gen_if import np_pkg::*; #(
  parameter int ADDR_W = 8
);
  logic                   pix_valid;
  logic                   pix_ready;
  logic [ADDR_W-1:0]      pix_addr;
  logic [3*COLOR_W-1:0]   pix_color;
  logic                   pix_last;

  modport master (output pix_valid, pix_addr, pix_color, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_addr, pix_color, pix_last, output pix_ready);
endinterface

// File: rtl/hue_wheel.sv
// Combinational 768-step hue wheel: three linear ramps R->G->B->R.
module hue_wheel import np_pkg::*; (
  input  logic [HUE_W-1:0]   hue,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);
  logic [COLOR_W-1:0] f;
  assign f = hue[COLOR_W-1:0];

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (hue[HUE_W-1 -: 2])
      2'd0: begin r = 8'd255 - f; g = f;             end
      2'd1: begin g = 8'd255 - f; b = f;             end
      2'd2: begin r = f;          b = 8'd255 - f;    end
      default: ;
    endcase
  end
endmodule

// File: rtl/rainbow_pattern_gen.sv
// Frame-timed pattern generator: one scaled GRB word per LED on a valid/ready stream.
module rainbow_pattern_gen import np_pkg::*; #(
  parameter int NUM_LEDS  = 150,
  parameter int ADDR_W    = 8,
  parameter int FRAME_DIV = 416666,
  parameter int HUE_STEP  = 3,
  parameter int PIX_STEP  = 5
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [7:0]            brightness,
  rainbow_pattern_gen_if.master pix,
  output logic                  frame_busy,
  output logic                  overrun,
  output logic                  status_led
);
  localparam int PRESC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(FRAME_DIV - 1);
  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [COLOR_W-1:0] scale_ch(input logic [COLOR_W-1:0] ch,
                                                  input logic [7:0] br);
    logic [16:0] p;
    p = {9'd0, ch} * ({9'd0, br} + 17'd1);
    return 8'(p >> 8);
  endfunction

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               pending;
  logic [HUE_W-1:0]   hue_off;
  logic [HUE_W-1:0]   hue_cur;
  logic [ADDR_W-1:0]  chase_pos;
  mode_t              mode_q;
  logic [7:0]         bright_q;

  logic                 start, hs, last_hs;
  logic [ADDR_W-1:0]    ld_addr;
  logic [HUE_W-1:0]     ld_hue, w_hue;
  mode_t                ld_mode;
  logic [7:0]           ld_bright;
  logic                 lit;
  logic [COLOR_W-1:0]   w_r, w_g, w_b;
  logic [3*COLOR_W-1:0] ld_color;

  assign start   = (state == IDLE) && enable && (tick || pending);
  assign hs      = (state == EMIT) && pix.pix_valid && pix.pix_ready;
  assign last_hs = hs && (pix.pix_addr == LAST_IDX);

  // A load in IDLE is a frame start and takes the live mode/brightness pins.
  always_comb begin
    ld_addr   = (state == IDLE) ? '0 : pix.pix_addr + 1'b1;
    ld_hue    = (state == IDLE) ? hue_off : hue_add(hue_cur, PIX_STEP);
    ld_mode   = (state == IDLE) ? mode_t'(mode) : mode_q;
    ld_bright = (state == IDLE) ? brightness : bright_q;
    w_hue     = (ld_mode == MODE_RAINBOW) ? ld_hue : hue_off;
    lit       = 1'b1;
    case (ld_mode)
      MODE_CHASE: lit = (ld_addr == chase_pos);
      MODE_OFF:   lit = 1'b0;
      default:    ;
    endcase
    ld_color = lit ? pack_grb(scale_ch(w_r, ld_bright), scale_ch(w_g, ld_bright),
                              scale_ch(w_b, ld_bright))
                   : '0;
  end

  hue_wheel u_wheel (.hue(w_hue), .r(w_r), .g(w_g), .b(w_b));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      presc         <= '0;
      tick          <= 1'b0;
      pending       <= 1'b0;
      hue_off       <= '0;
      chase_pos     <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_addr  <= '0;
      pix.pix_color <= '0;
      pix.pix_last  <= 1'b0;
      frame_busy    <= 1'b0;
      overrun       <= 1'b0;
      status_led    <= 1'b0;
    end else begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      tick  <= (presc == PRESC_LAST);
      case (state)
        IDLE: begin
          if (start) begin
            state         <= EMIT;
            pending       <= 1'b0;
            mode_q        <= mode_t'(mode);
            bright_q      <= brightness;
            hue_cur       <= ld_hue;
            pix.pix_valid <= 1'b1;
            pix.pix_addr  <= ld_addr;
            pix.pix_color <= ld_color;
            pix.pix_last  <= (ld_addr == LAST_IDX);
            frame_busy    <= 1'b1;
            status_led    <= ~status_led;
          end
        end
        EMIT: begin
          if (tick) begin
            pending <= 1'b1;
            if (pending) overrun <= 1'b1;
          end
          if (last_hs) begin
            state         <= IDLE;
            pix.pix_valid <= 1'b0;
            pix.pix_last  <= 1'b0;
            frame_busy    <= 1'b0;
            hue_off       <= hue_add(hue_off, HUE_STEP);
            chase_pos     <= (chase_pos == LAST_IDX) ? '0 : chase_pos + 1'b1;
          end else if (hs) begin
            hue_cur       <= ld_hue;
            pix.pix_addr  <= ld_addr;
            pix.pix_color <= ld_color;
            pix.pix_last  <= (ld_addr == LAST_IDX);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rainbow_pattern_gen.sv
// Scoreboard bench for rainbow_pattern_gen: 4-LED frames, short frame timer.
module tb_rainbow_pattern_gen;
  localparam int NL = 4;
  localparam int AW = 8;
  localparam int HS = 3;
  localparam int PS = 5;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] color;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] brightness = 8'd255;
  logic       frame_busy, overrun, status_led;
  logic       o_busy, o_overrun, o_led;
  bit         rand_ready = 1'b0;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   fails = 0;
  int   hue_m = 0;
  int   chase_m = 0;
  bit   led_m = 1'b0;

  rainbow_pattern_gen_if #(.ADDR_W(AW)) pix_if();
  rainbow_pattern_gen_if #(.ADDR_W(AW)) ovr_if();

  rainbow_pattern_gen #(.NUM_LEDS(NL), .ADDR_W(AW), .FRAME_DIV(10), .HUE_STEP(HS), .PIX_STEP(PS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .brightness(brightness),
    .pix(pix_if), .frame_busy(frame_busy), .overrun(overrun), .status_led(status_led));

  rainbow_pattern_gen #(.NUM_LEDS(NL), .ADDR_W(AW), .FRAME_DIV(2), .HUE_STEP(HS), .PIX_STEP(PS)) u_ovr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .brightness(brightness),
    .pix(ovr_if), .frame_busy(o_busy), .overrun(o_overrun), .status_led(o_led));

  assign ovr_if.pix_ready = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    pix_if.pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  function automatic logic [23:0] wheel_m(input int h);
    int f, r, g, b;
    f = h % 256;
    if (h < 256)      begin r = 255 - f; g = f;       b = 0;       end
    else if (h < 512) begin r = 0;       g = 255 - f; b = f;       end
    else              begin r = f;       g = 0;       b = 255 - f; end
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  function automatic logic [23:0] scale_m(input logic [23:0] c, input int br);
    int g, r, b;
    g = (int'(c[23:16]) * (br + 1)) / 256;
    r = (int'(c[15:8])  * (br + 1)) / 256;
    b = (int'(c[7:0])   * (br + 1)) / 256;
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  // Stall hold and in-order delivery of every pixel handed over.
  logic [7:0]  s_addr;
  logic [23:0] s_color;
  bit          s_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_pend = 1'b0;
    end else begin
      if (s_pend) begin
        checks++;
        if (pix_if.pix_valid !== 1'b1 || pix_if.pix_addr !== s_addr || pix_if.pix_color !== s_color) begin
          fails++;
          $display("FAIL stall_hold: valid=%0b addr=%0d color=%06h, required valid=1 addr=%0d color=%06h",
                   pix_if.pix_valid, pix_if.pix_addr, pix_if.pix_color, s_addr, s_color);
        end
      end
      s_pend  = pix_if.pix_valid && !pix_if.pix_ready;
      s_addr  = pix_if.pix_addr;
      s_color = pix_if.pix_color;
      if (pix_if.pix_valid && pix_if.pix_ready) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pixel: addr=%0d color=%06h, required no pixel",
                   pix_if.pix_addr, pix_if.pix_color);
        end else begin
          e = q.pop_front();
          if (pix_if.pix_addr !== e.addr || pix_if.pix_color !== e.color || pix_if.pix_last !== e.last) begin
            fails++;
            $display("FAIL pixel: addr=%0d color=%06h last=%0b, required addr=%0d color=%06h last=%0b",
                     pix_if.pix_addr, pix_if.pix_color, pix_if.pix_last, e.addr, e.color, e.last);
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [1:0] m, input logic [7:0] b, input bit use_tbl,
                            input logic [23:0] c0, input logic [23:0] c1,
                            input logic [23:0] c2, input logic [23:0] c3);
    logic [23:0] tbl [4];
    logic [23:0] col;
    tbl[0] = c0; tbl[1] = c1; tbl[2] = c2; tbl[3] = c3;
    mode = m;
    brightness = b;
    for (int i = 0; i < NL; i++) begin
      if (use_tbl) col = tbl[i];
      else begin
        case (m)
          2'd0:    col = wheel_m((hue_m + i * PS) % 768);
          2'd1:    col = wheel_m(hue_m);
          2'd2:    col = (i == chase_m) ? wheel_m(hue_m) : 24'h0;
          default: col = 24'h0;
        endcase
        col = scale_m(col, int'(b));
      end
      q.push_back('{addr: 8'(i), color: col, last: (i == NL - 1)});
    end
    hue_m   = (hue_m + HS) % 768;
    chase_m = (chase_m + 1) % NL;
    led_m   = ~led_m;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (frame_busy && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] b, input bit use_tbl,
                           input logic [23:0] c0, input logic [23:0] c1,
                           input logic [23:0] c2, input logic [23:0] c3, input bit perturb);
    int n;
    wait_idle();
    push_frame(m, b, use_tbl, c0, c1, c2, c3);
    n = 0;
    while (!frame_busy && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!frame_busy) begin
      fails++;
      $display("FAIL frame_start: frame_busy=%0b after %0d cycles, required 1", frame_busy, n);
    end
    if (perturb) begin mode = 2'd3; brightness = 8'd0; end
    n = 0;
    while (frame_busy && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (frame_busy) begin
      fails++;
      $display("FAIL frame_end: frame_busy=%0b after %0d cycles, required 0", frame_busy, n);
    end
    checks++;
    if (status_led !== led_m) begin
      fails++;
      $display("FAIL status_led: got %0b, required %0b", status_led, led_m);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (pix_if.pix_valid !== 1'b0 || pix_if.pix_addr !== 8'd0 || pix_if.pix_color !== 24'd0 ||
        pix_if.pix_last !== 1'b0 || frame_busy !== 1'b0 || overrun !== 1'b0 || status_led !== 1'b0) begin
      fails++;
      $display("FAIL %s: valid=%0b addr=%0d color=%06h last=%0b busy=%0b ovr=%0b led=%0b, required all 0",
               tag, pix_if.pix_valid, pix_if.pix_addr, pix_if.pix_color, pix_if.pix_last,
               frame_busy, overrun, status_led);
    end
  endtask

  task automatic check_ovr(input logic want, input string tag);
    checks++;
    if (o_overrun !== want) begin
      fails++;
      $display("FAIL %s: overrun=%0b, required %0b", tag, o_overrun, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    check_ovr(1'b0, "ovr_reset");
    rst_n = 1'b1;

    // First two rainbow frames, then 254 more so the hue offset wraps to 0.
    run_frame(2'd0, 8'd255, 1'b1, 24'h00FF00, 24'h05FA00, 24'h0AF500, 24'h0FF000, 1'b0);
    run_frame(2'd0, 8'd255, 1'b1, 24'h03FC00, 24'h08F700, 24'h0DF200, 24'h12ED00, 1'b0);
    check_ovr(1'b1, "ovr_set");
    for (int k = 3; k <= 256; k++) run_frame(2'd0, 8'd255, 1'b0, 0, 0, 0, 0, 1'b0);
    run_frame(2'd0, 8'd255, 1'b1, 24'h00FF00, 24'h05FA00, 24'h0AF500, 24'h0FF000, 1'b0);

    rand_ready = 1'b1;
    for (int k = 0; k < 4; k++) run_frame(2'd0, 8'd200, 1'b0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 2; k++) run_frame(2'd1, 8'd90, 1'b0, 0, 0, 0, 0, 1'b0);
    rand_ready = 1'b0;
    run_frame(2'd1, 8'd255, 1'b0, 0, 0, 0, 0, 1'b1);

    // Frame ticks with enable low must not start frames.
    enable = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (frame_busy) seen = 1'b1; end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL enable_low: frame started=%0b, required 0", seen);
    end
    enable = 1'b1;
    run_frame(2'd0, 8'd255, 1'b0, 0, 0, 0, 0, 1'b0);

    // Reset while pixel 2 is on the bus.
    wait_idle();
    push_frame(2'd0, 8'd255, 1'b0, 0, 0, 0, 0);
    n = 0;
    while (!(pix_if.pix_valid === 1'b1 && pix_if.pix_addr === 8'd2) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 100) begin
      fails++;
      $display("FAIL reach_pixel2: addr=%0d valid=%0b, required addr=2 valid=1",
               pix_if.pix_addr, pix_if.pix_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset("reset_mid_frame");
    q.delete();
    hue_m = 0; chase_m = 0; led_m = 1'b0;
    rst_n = 1'b1;

    // Chase from a clean frame state: lit index 0,1,2,3,0.
    run_frame(2'd2, 8'd255, 1'b1, 24'h00FF00, 24'h0, 24'h0, 24'h0, 1'b0);
    run_frame(2'd2, 8'd255, 1'b1, 24'h0, 24'h03FC00, 24'h0, 24'h0, 1'b0);
    run_frame(2'd2, 8'd255, 1'b1, 24'h0, 24'h0, 24'h06F900, 24'h0, 1'b0);
    run_frame(2'd2, 8'd255, 1'b1, 24'h0, 24'h0, 24'h0, 24'h09F600, 1'b0);
    run_frame(2'd2, 8'd255, 1'b1, 24'h0CF300, 24'h0, 24'h0, 24'h0, 1'b0);
    check_ovr(1'b1, "ovr_after_reset");

    // Brightness scaling from hue 0, then off mode, then solid.
    wait_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_again");
    hue_m = 0; chase_m = 0; led_m = 1'b0;
    rst_n = 1'b1;
    run_frame(2'd0, 8'd127, 1'b1, 24'h007F00, 24'h027D00, 24'h057A00, 24'h077800, 1'b0);
    run_frame(2'd0, 8'd0, 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0);
    run_frame(2'd3, 8'd255, 1'b1, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0);
    run_frame(2'd1, 8'd255, 1'b1, 24'h09F600, 24'h09F600, 24'h09F600, 24'h09F600, 1'b0);
    run_frame(2'd0, 8'd255, 1'b0, 0, 0, 0, 0, 1'b0);
    check_ovr(1'b1, "ovr_sticky");

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: %0d pixels outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
